// File: rtl/spi_slave_mem_if.sv
// SPI pins and local memory port for a single slave-select line.
// Latency: none, this is a wiring bundle only.
// Backpressure: none; SPI has no flow control and the memory always accepts.
interface spi_slave_mem_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DWIDTH-1:0] mem_rdata;
  logic              frame_done;
  logic              frame_err;

  // Responder view: consumes SPI pins and read data, produces memory strobes.
  modport slave (
    input  sclk, cs_n, mosi, mem_rdata,
    output miso, miso_oe, mem_addr, mem_wdata, mem_we, mem_re, frame_done, frame_err
  );

  // SPI master plus memory view.
  modport master (
    output sclk, cs_n, mosi, mem_rdata,
    input  miso, miso_oe, mem_addr, mem_wdata, mem_we, mem_re, frame_done, frame_err
  );
endinterface

// File: rtl/spi_slave_mem.sv
// SPI mode-0 responder turning each {rw, addr, data} frame into one memory word access.
// Latency: strobe 1 clk after the last synchronized address/data rise; read data loaded 2 clks after it.
// Backpressure: none; the master clock is oversampled (fclk >= 8x fsclk) and the memory never stalls.
module spi_slave_mem #(
  parameter int AWIDTH      = 12,
  parameter int DWIDTH      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_mem_if.slave bus
);
  localparam int MW = (AWIDTH > DWIDTH) ? AWIDTH : DWIDTH;
  localparam int CW = $clog2(MW + 1);
  localparam logic [CW-1:0] ALAST = CW'(AWIDTH - 1);
  localparam logic [CW-1:0] DLAST = CW'(DWIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_REQ, RD_LOAD, RDATA, WDATA, DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, flush_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_s, mosi_s, flushed, rise, fall;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MW-2:0]     rx_q, rx_d;
  logic [DWIDTH-1:0] tx_q, tx_d;
  logic              rw_q, rw_d;
  logic              armed_q, armed_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              we_q, we_d, re_q, re_d;
  logic              done_q, done_d, err_q, err_d, oe_q, oe_d;

  // Input synchronizers; flush_q marks when the sync chains hold real pin samples after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign flushed = flush_q[SYNC_STAGES-1];
  assign rise    = ~cs_s & sclk_s & ~sclk_prev_q;
  assign fall    = ~cs_s & ~sclk_s & sclk_prev_q;

  // State register, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      rw_q    <= 1'b0;
      armed_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rw_q    <= rw_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      done_q  <= done_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
    end
  end

  // Frame sequencing. A frame starts only after cs_n has been seen high, so a reset
  // released mid-frame (cs_n still low) stays idle until the master starts a new frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rw_d    = rw_q;
    armed_d = armed_q | (flushed & cs_s);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    oe_d    = oe_q;
    case (state_q)
      IDLE: begin
        if (armed_q && flushed && !cs_s) begin
          state_d = CMD;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          armed_d = 1'b0;
          oe_d    = 1'b1;
        end
      end
      DONE: begin
        if (cs_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
          oe_d    = 1'b0;
          tx_d    = '0;
        end
      end
      default: begin
        if (cs_s) begin
          // Early cs_n rise: drop the frame; any read already issued is simply discarded.
          state_d = IDLE;
          err_d   = 1'b1;
          oe_d    = 1'b0;
          tx_d    = '0;
        end else begin
          case (state_q)
            CMD: begin
              if (rise) begin
                rw_d    = mosi_s;
                cnt_d   = '0;
                state_d = ADDR;
              end
            end
            ADDR: begin
              if (rise) begin
                rx_d  = {rx_q[MW-3:0], mosi_s};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ALAST) begin
                  addr_d  = {rx_q[AWIDTH-2:0], mosi_s};
                  cnt_d   = '0;
                  re_d    = ~rw_q;
                  state_d = rw_q ? WDATA : RD_REQ;
                end
              end
            end
            RD_REQ:  state_d = RD_LOAD;
            RD_LOAD: begin
              // Read data is valid this cycle, one clk after mem_re.
              tx_d    = bus.mem_rdata;
              state_d = RDATA;
            end
            RDATA: begin
              if (rise) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DLAST) begin
                  state_d = DONE;
                end
              end else if (fall && cnt_q != '0) begin
                // The fall before the first data rise must leave the MSB on miso.
                tx_d = {tx_q[DWIDTH-2:0], 1'b0};
              end
            end
            WDATA: begin
              if (rise) begin
                rx_d  = {rx_q[MW-3:0], mosi_s};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DLAST) begin
                  wdata_d = {rx_q[DWIDTH-2:0], mosi_s};
                  we_d    = 1'b1;
                  state_d = DONE;
                end
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  assign bus.miso       = tx_q[DWIDTH-1];
  assign bus.miso_oe    = oe_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_re     = re_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_spi_slave_mem.sv
// Randomized bench for spi_slave_mem: SPI master driver, memory model, event scoreboard.
// Latency: expected strobes are queued per frame and matched in order as they appear.
// Backpressure: none; the memory model answers every read exactly 1 clk later.
module tb_spi_slave_mem;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int K_WE = 0, K_RE = 1, K_DONE = 2, K_ERR = 3;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  logic [31:0] ref_mem   [logic [11:0]];
  logic [31:0] mem_model [logic [11:0]];

  spi_slave_mem_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  spi_slave_mem #(.AWIDTH(AW), .DWIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [11:0] a);
    return 32'h5A5A_0000 | {20'h0, a};
  endfunction

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  // Memory: writes on mem_we, read data valid exactly one clk after mem_re, junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_re)
      bus.mem_rdata <= mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : dflt(bus.mem_addr);
    else
      bus.mem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected no event", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        failures++;
        $display("FAIL event_order: got kind %0d addr %0h data %0h, expected kind %0d addr %0h data %0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every strobe the DUT raises is matched against the head of the queue.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (bus.mem_we)     observe(K_WE, bus.mem_addr, bus.mem_wdata);
      if (bus.mem_re)     observe(K_RE, bus.mem_addr, 32'h0);
      if (bus.frame_done) observe(K_DONE, 12'h0, 32'h0);
      if (bus.frame_err)  observe(K_ERR, 12'h0, 32'h0);
    end
  endtask

  task automatic half_period();
    repeat (5) @(negedge clk);
  endtask

  // One SPI frame of nrise clocks; rst_at >= 0 pulses rst_n just before that rise.
  task automatic run_frame(input bit rw, input logic [11:0] a, input logic [31:0] d,
                           input int nrise, input int rst_at);
    logic [44:0] bits;
    logic [31:0] cap;
    logic [31:0] exp_rd;
    bit          full;
    bits   = {rw, a, d};
    cap    = '0;
    full   = (nrise >= 45) && (rst_at < 0);
    exp_rd = ref_read(a);
    if (rst_at < 0) begin
      if (rw) begin
        if (full) begin
          push(K_WE, a, d);
          ref_mem[a] = d;
        end
      end else if (nrise >= 13) begin
        push(K_RE, a, 32'h0);
      end
      push(full ? K_DONE : K_ERR, 12'h0, 32'h0);
    end
    @(negedge clk);
    bus.cs_n = 1'b0;
    bus.mosi = bits[44];
    half_period();
    chk("miso_oe_in_frame", {63'h0, bus.miso_oe}, 64'h1);
    chk("miso_low_in_cmd", {63'h0, bus.miso}, 64'h0);
    for (int i = 0; i < nrise; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("outputs_in_reset",
            {14'h0, bus.miso, bus.miso_oe, bus.mem_addr, bus.mem_wdata,
             bus.mem_we, bus.mem_re, bus.frame_done, bus.frame_err}, 64'h0);
        rst_n = 1'b1;
      end
      if (i >= 13 && i < 45) cap = {cap[30:0], bus.miso};
      bus.sclk = 1'b1;
      half_period();
      bus.sclk = 1'b0;
      bus.mosi = (i + 1 < 45) ? bits[43-i] : 1'($urandom);
      half_period();
    end
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (20) @(negedge clk);
    chk("miso_oe_between_frames", {63'h0, bus.miso_oe}, 64'h0);
    if (full && !rw) chk("read_data", {32'h0, cap}, {32'h0, exp_rd});
  endtask

  initial begin
    logic [11:0] pool [4];
    logic [11:0] ra;
    int          nr;
    bit          rrw;
    pool[0] = 12'h010; pool[1] = 12'h020; pool[2] = 12'h3FC; pool[3] = 12'h044;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    mem_model[12'h3FC] = 32'hCAFE_F00D;
    ref_mem[12'h3FC]   = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {14'h0, bus.miso, bus.miso_oe, bus.mem_addr, bus.mem_wdata,
         bus.mem_we, bus.mem_re, bus.frame_done, bus.frame_err}, 64'h0);
    rst_n = 1'b1;
    fork
      monitor_loop();
    join_none
    repeat (20) @(negedge clk);

    run_frame(1'b1, 12'h010, 32'hDEAD_BEEF, 45, -1);  // write
    run_frame(1'b0, 12'h3FC, 32'h0, 45, -1);          // read preloaded word
    run_frame(1'b1, 12'h044, 32'h1111_2222, 20, -1);  // abort after 20 bits
    run_frame(1'b1, 12'h044, 32'hA5A5_5A5A, 45, -1);  // recovery frame
    run_frame(1'b1, 12'h0AB, 32'h7777_8888, 45, 30);  // reset mid-frame
    run_frame(1'b0, 12'h000, 32'h0, 45, -1);          // read after reset
    run_frame(1'b1, 12'h020, 32'h1234_5678, 45, -1);  // back-to-back write/read
    run_frame(1'b0, 12'h020, 32'h0, 45, -1);
    run_frame(1'b1, 12'h0F0, 32'h0BAD_F00D, 50, -1);  // extra sclk edges ignored
    chk("wdata_after_extra_clocks", {32'h0, bus.mem_wdata}, {32'h0, 32'h0BAD_F00D});
    run_frame(1'b0, 12'h044, 32'h0, 45, -1);

    for (int k = 0; k < 16; k++) begin
      rrw = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 4) == 4) ? 12'($urandom) : pool[$urandom_range(0, 3)];
      nr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 44)) : 45;
      run_frame(rrw, ra, $urandom, nr, -1);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave_mem.md
Name: spi_slave_mem

Overview:
SPI mode-0 responder that terminates frames issued by the SPI master and converts each into a single word access on a local synchronous memory port. It is one instance per slave select line; the master side fans out NSLAVES chip selects. SPI pins are oversampled in the system clock domain, so no SCLK clock domain exists inside the block. Frame format, MSB first: 1 R/W bit (1 = write), AWIDTH address bits, DWIDTH data bits.

Parameters:
AWIDTH, 12, memory byte-address width (32x1024 bits / 8 bytes, clog2). The address is passed through unaligned; the memory handles alignment.
DWIDTH, 32, data word width and data-phase bit count.
SYNC_STAGES, 2, synchronizer depth on sclk, cs_n and mosi.

Ports:
clk  in  1  system clock; fclk must be at least 8x fsclk.
rst_n  in  1  asynchronous active-low reset.
sclk  in  1  SPI clock from the master, idle low.
cs_n  in  1  slave select, active low.
mosi  in  1  master-out data.
miso  out  1  slave-out data.
miso_oe  out  1  tri-state enable for miso; high only while cs_n is synchronized low.
mem_addr  out  AWIDTH  memory address.
mem_wdata  out  DWIDTH  write data.
mem_we  out  1  one-clk write strobe.
mem_re  out  1  one-clk read strobe.
mem_rdata  in  DWIDTH  read data, valid exactly 1 clk after mem_re.
frame_done  out  1  one-clk pulse when a complete frame ends.
frame_err  out  1  one-clk pulse when cs_n rises before the frame is complete.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift registers and counters 0, synchronizers reset to idle levels (sclk=0, cs_n=1, mosi=0).
- Inputs pass through SYNC_STAGES flops. Rise and fall events come from the last two synchronized sclk samples and are evaluated only when synced cs_n=0.
- Sampling: mosi is sampled on the sclk rise event. miso updates on the sclk fall event, and miso = shift-out MSB combinationally from the tx register.
- States and transitions:
  - IDLE: on cs_n fall go to CMD; clear the bit counter; set miso_oe=1.
  - CMD: 1 rise, latch rw, go to ADDR.
  - ADDR: shift AWIDTH bits. On the last rise, drive mem_addr.
    - Write: go to WDATA.
    - Read: assert mem_re on the next clk, load mem_rdata into the tx register 1 clk later, go to RDATA.
  - WDATA: shift DWIDTH bits. On the last rise, mem_wdata is set and mem_we pulses the next clk; go to DONE.
  - RDATA: each fall shifts the tx register left. The tx MSB is on miso before the first data rise. After DWIDTH rises go to DONE.
  - DONE: ignore further sclk edges. On cs_n rise, pulse frame_done, go to IDLE, miso_oe=0.
- Abort: cs_n rise in CMD, ADDR, WDATA or RDATA pulses frame_err and returns to IDLE.
  - No mem_we is issued.
  - A mem_re already issued is allowed; its data is discarded.
- During a read, mem_we is never asserted. mem_re is issued at most once per frame.
- Read latency budget: address-last rise detected at t, mem_re at t+1, tx loaded at t+2. The first fall is detected no earlier than t+4 at fclk ≥ 8·fsclk.
- Bit counter width is clog2(max(AWIDTH, DWIDTH)+1) and is reset on every new frame.
- miso holds its value between fall events. miso is 0 in IDLE and during CMD/ADDR.
- rst_n asserted mid-frame: immediate return to reset values. There is no strobe after release until a new cs_n fall.
- A cs_n fall arriving in the same clk as the DONE→IDLE exit is seen the next clk. Back-to-back frames with a cs_n high time of ≥ 2 sclk periods work.

Test Plan:
- Write frame: rw=1, addr 0x010, data 0xDEADBEEF. Expect one mem_we pulse with mem_addr=0x010 and mem_wdata=0xDEADBEEF, then frame_done after cs_n rises; no mem_re.
- Read frame: rw=0, addr 0x3FC, memory model returns 0xCAFEF00D 1 clk after mem_re. Expect one mem_re with mem_addr=0x3FC; master captures 0xCAFEF00D on miso MSB first; no mem_we.
- Abort: cs_n raised after 20 write-frame bits. Expect frame_err=1 for 1 clk, mem_we never asserted, and the next full frame decodes correctly.
- Reset: rst_n pulsed low at bit 30 of a write. Expect all outputs 0 and no mem_we; a following read of 0x000 completes normally.
- Back-to-back: write 0x12345678 to 0x020, then read 0x020 (model holds the value). Expect miso returns 0x12345678, two frame_done pulses, and miso_oe=0 between frames.
- Extra clocks: 50 sclk cycles in a 45-bit frame. Expect edges beyond bit 45 ignored, a single mem_we, and unchanged mem_wdata.
